// File: rtl/hatch_pkg.sv
// Shared definitions for the hatching sequencer and the dot-matrix display driver.
package hatch_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2,
        DONE = 2'd3
    } hatch_state_t;

    localparam int DEF_CLK_HZ       = 1000;
    localparam int HATCH_NUM_STAGES = 12;

endpackage

// File: rtl/key_debounce.sv
// Two-flop synchroniser, stability-count debouncer and rising-edge press pulse
// for an asynchronous push-button.
module key_debounce #(
    parameter int DEB_CYC = 20
) (
    input  logic clk,
    input  logic rst,
    input  logic key_raw,
    output logic level,
    output logic press
);

    // After reset the level silently tracks the synchronised key so that a key
    // held through reset cannot produce a press; the extra two cycles cover the
    // synchroniser latency.
    localparam int ARM_CYC = DEB_CYC + 2;
    localparam int CW      = $clog2(ARM_CYC) + 1;
    localparam logic [CW-1:0] DEB_LAST = CW'(DEB_CYC - 1);
    localparam logic [CW-1:0] ARM_LAST = CW'(ARM_CYC - 1);

    logic          sync1;
    logic          sync2;
    logic          armed;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            armed <= 1'b0;
            cnt   <= '0;
            level <= 1'b0;
            press <= 1'b0;
        end else begin
            sync1 <= key_raw;
            sync2 <= sync1;
            press <= 1'b0;
            if (!armed) begin
                level <= sync2;
                if (cnt == ARM_LAST) begin
                    armed <= 1'b1;
                    cnt   <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else if (sync2 != level) begin
                if (cnt == DEB_LAST) begin
                    level <= sync2;
                    press <= sync2;
                    cnt   <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/hatch_stage_ctrl.sv
// Incubation sequencer: steps the display stage on a fixed time base, freezes
// while the temperature is abnormal, and is started/aborted by a debounced key.
module hatch_stage_ctrl
    import hatch_pkg::*;
#(
    parameter int CLK_HZ     = DEF_CLK_HZ,
    parameter int STAGE_SEC  = 2,
    parameter int NUM_STAGES = HATCH_NUM_STAGES,
    parameter int DEB_MS     = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_raw,
    input  logic       temp_ok_raw,
    output logic [3:0] num,
    output logic       st,
    output logic       temp,
    output logic       done,
    output logic       stage_pulse
);

    localparam int DEB_CYC   = DEB_MS * CLK_HZ / 1000;
    localparam int STAGE_CYC = STAGE_SEC * CLK_HZ;
    localparam int TW        = $clog2(STAGE_CYC);
    localparam logic [TW-1:0] TIMER_LAST = TW'(STAGE_CYC - 1);
    localparam logic [3:0]    LAST_STAGE = 4'(NUM_STAGES - 1);

    hatch_state_t  state, state_n;
    logic [3:0]    num_n;
    logic [TW-1:0] timer, timer_n;
    logic          pulse_n;
    logic          press;
    logic          key_level_unused;
    logic          temp_s1;
    logic          temp_ok_s;
    logic          expire;

    key_debounce #(
        .DEB_CYC (DEB_CYC)
    ) u_key (
        .clk     (clk),
        .rst     (rst),
        .key_raw (key_raw),
        .level   (key_level_unused),
        .press   (press)
    );

    assign expire = (state == RUN) && (timer == TIMER_LAST);

    // Priority inside a cycle: press, then temperature fault, then expire.
    always_comb begin
        state_n = state;
        num_n   = num;
        timer_n = timer;
        pulse_n = 1'b0;
        case (state)
            IDLE: begin
                num_n   = '0;
                timer_n = '0;
                if (press) state_n = RUN;
            end
            RUN: begin
                if (press) begin
                    state_n = IDLE;
                    num_n   = '0;
                    timer_n = '0;
                end else if (!temp_ok_s) begin
                    state_n = HOLD;
                end else if (expire) begin
                    timer_n = '0;
                    if (num < LAST_STAGE) begin
                        num_n   = num + 4'd1;
                        pulse_n = 1'b1;
                    end else begin
                        state_n = DONE;
                    end
                end else begin
                    timer_n = timer + 1'b1;
                end
            end
            HOLD: begin
                if (press) begin
                    state_n = IDLE;
                    num_n   = '0;
                    timer_n = '0;
                end else if (temp_ok_s) begin
                    state_n = RUN;
                end
            end
            DONE: begin
                num_n = LAST_STAGE;
                if (press) begin
                    state_n = IDLE;
                    num_n   = '0;
                    timer_n = '0;
                end
            end
            default: begin
                state_n = IDLE;
                num_n   = '0;
                timer_n = '0;
            end
        endcase
    end

    // Outputs are registered from the next state so they change with it;
    // temp lags one cycle because it is built from the registered st.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            num         <= '0;
            timer       <= '0;
            st          <= 1'b0;
            done        <= 1'b0;
            temp        <= 1'b0;
            stage_pulse <= 1'b0;
            temp_s1     <= 1'b0;
            temp_ok_s   <= 1'b0;
        end else begin
            temp_s1     <= temp_ok_raw;
            temp_ok_s   <= temp_s1;
            state       <= state_n;
            num         <= num_n;
            timer       <= timer_n;
            stage_pulse <= pulse_n;
            st          <= (state_n != IDLE);
            done        <= (state_n == DONE);
            temp        <= st & ~temp_ok_s;
        end
    end

endmodule

// File: tb/tb_hatch_stage_ctrl.sv
// Directed bench for hatch_stage_ctrl with STAGE_CYC=1000 and DEB_CYC=5.
module tb_hatch_stage_ctrl;

    logic       clk;
    logic       rst;
    logic       key_raw;
    logic       temp_ok_raw;
    logic [3:0] num;
    logic       st;
    logic       temp;
    logic       done;
    logic       stage_pulse;

    int n_tests;
    int n_fail;
    int pulse_cnt;
    int st_cnt;
    int base;

    hatch_stage_ctrl #(
        .CLK_HZ     (1000),
        .STAGE_SEC  (1),
        .NUM_STAGES (12),
        .DEB_MS     (5)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .key_raw     (key_raw),
        .temp_ok_raw (temp_ok_raw),
        .num         (num),
        .st          (st),
        .temp        (temp),
        .done        (done),
        .stage_pulse (stage_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        pulse_cnt = 0;
        st_cnt    = 0;
    end

    always @(negedge clk) begin
        if (stage_pulse === 1'b1) pulse_cnt = pulse_cnt + 1;
        if (st === 1'b1) st_cnt = st_cnt + 1;
    end

    // Leaves the bench 1 ns after the n-th rising edge.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_tests++;
        assert (obs === exp_v)
        else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    // Press lands 7 edges after the key rises; RUN (st=1) one edge later.
    task automatic apply_stimulus_session();
        key_raw = 1'b1;
        tick(8);
        check_output("session_st", 32'(st), 1);
        check_output("session_num", 32'(num), 0);
        tick(12);
        key_raw = 1'b0;
    endtask

    initial begin
        n_tests     = 0;
        n_fail      = 0;
        rst         = 1'b1;
        key_raw     = 1'b0;
        temp_ok_raw = 1'b1;
        tick(3);
        check_output("rst_num", 32'(num), 0);
        check_output("rst_st", 32'(st), 0);
        check_output("rst_temp", 32'(temp), 0);
        check_output("rst_done", 32'(done), 0);
        check_output("rst_pulse", 32'(stage_pulse), 0);
        rst = 1'b0;
        tick(20);

        // Clean press, then a full fault-free run to DONE.
        base    = pulse_cnt;
        key_raw = 1'b1;
        tick(7);
        check_output("press_pre_st", 32'(st), 0);
        tick(1);
        check_output("run_entry_st", 32'(st), 1);
        check_output("run_entry_num", 32'(num), 0);
        tick(12);
        key_raw = 1'b0;
        tick(987);
        check_output("stage1_early_num", 32'(num), 0);
        check_output("stage1_early_pulse", 32'(stage_pulse), 0);
        tick(1);
        check_output("stage1_num", 32'(num), 1);
        check_output("stage1_pulse", 32'(stage_pulse), 1);
        for (int k = 2; k <= 11; k++) begin
            tick(1000);
            check_output("run_num", 32'(num), 32'(k));
            check_output("run_pulse", 32'(stage_pulse), 1);
        end
        tick(1000);
        check_output("done_flag", 32'(done), 1);
        check_output("done_num", 32'(num), 11);
        check_output("done_st", 32'(st), 1);
        check_output("done_pulse", 32'(stage_pulse), 0);
        check_output("pulse_total", 32'(pulse_cnt - base), 11);
        tick(50);
        check_output("done_hold_num", 32'(num), 11);
        check_output("done_hold_temp", 32'(temp), 0);
        key_raw = 1'b1;
        tick(8);
        check_output("done_exit_st", 32'(st), 0);
        check_output("done_exit_num", 32'(num), 0);
        check_output("done_exit_done", 32'(done), 0);
        tick(12);
        key_raw = 1'b0;
        tick(20);

        // Temperature fault for 300 cycles starting at RUN cycle 400: 301 edges
        // without a timer increment, so stage 1 arrives at RUN cycle 1301.
        apply_stimulus_session();
        tick(388);
        temp_ok_raw = 1'b0;
        tick(2);
        check_output("hold_temp_lag", 32'(temp), 0);
        tick(1);
        check_output("hold_temp", 32'(temp), 1);
        check_output("hold_st", 32'(st), 1);
        tick(297);
        check_output("hold_num", 32'(num), 0);
        temp_ok_raw = 1'b1;
        tick(600);
        check_output("resume_early_num", 32'(num), 0);
        check_output("resume_temp", 32'(temp), 0);
        tick(1);
        check_output("resume_num", 32'(num), 1);
        check_output("resume_pulse", 32'(stage_pulse), 1);

        // Abort from RUN at stage 5.
        tick(4000);
        check_output("abort_pre_num", 32'(num), 5);
        key_raw = 1'b1;
        tick(8);
        check_output("abort_st", 32'(st), 0);
        check_output("abort_num", 32'(num), 0);
        check_output("abort_temp", 32'(temp), 0);
        tick(12);
        key_raw = 1'b0;
        tick(20);

        // Fault seen in the expire cycle blocks that advance; it retries on resume.
        apply_stimulus_session();
        tick(985);
        temp_ok_raw = 1'b0;
        tick(3);
        check_output("expfault_num", 32'(num), 0);
        check_output("expfault_pulse", 32'(stage_pulse), 0);
        check_output("expfault_temp", 32'(temp), 1);
        check_output("expfault_st", 32'(st), 1);
        tick(5);
        temp_ok_raw = 1'b1;
        tick(3);
        check_output("expfault_resume_early", 32'(num), 0);
        tick(1);
        check_output("expfault_resume_num", 32'(num), 1);
        check_output("expfault_resume_pulse", 32'(stage_pulse), 1);

        // Press pulse coincides with the next expire cycle: abort wins.
        tick(992);
        base    = pulse_cnt;
        key_raw = 1'b1;
        tick(7);
        check_output("pexp_pre_num", 32'(num), 1);
        tick(1);
        check_output("pexp_st", 32'(st), 0);
        check_output("pexp_num", 32'(num), 0);
        check_output("pexp_pulse", 32'(stage_pulse), 0);
        tick(3);
        check_output("pexp_no_pulse", 32'(pulse_cnt - base), 0);
        tick(9);
        key_raw = 1'b0;
        tick(20);

        // Bouncing key: 3-cycle toggles never reach the 5-cycle stability count.
        base = st_cnt;
        for (int i = 0; i < 10; i++) begin
            key_raw = ~key_raw;
            tick(3);
        end
        key_raw = 1'b0;
        tick(20);
        check_output("bounce_st", 32'(st), 0);
        check_output("bounce_st_seen", 32'(st_cnt - base), 0);

        // Asynchronous reset in HOLD at stage 7 with the key held through release.
        apply_stimulus_session();
        tick(7088);
        check_output("rsthold_num", 32'(num), 7);
        temp_ok_raw = 1'b0;
        tick(3);
        check_output("rsthold_temp", 32'(temp), 1);
        key_raw     = 1'b1;
        tick(2);
        #2;
        rst = 1'b1;
        #1;
        check_output("async_num", 32'(num), 0);
        check_output("async_st", 32'(st), 0);
        check_output("async_temp", 32'(temp), 0);
        check_output("async_done", 32'(done), 0);
        check_output("async_pulse", 32'(stage_pulse), 0);
        temp_ok_raw = 1'b1;
        tick(3);
        rst  = 1'b0;
        base = st_cnt;
        tick(40);
        check_output("held_key_st", 32'(st), 0);
        check_output("held_key_st_seen", 32'(st_cnt - base), 0);
        key_raw = 1'b0;
        tick(20);
        key_raw = 1'b1;
        tick(8);
        check_output("repress_st", 32'(st), 1);
        check_output("repress_num", 32'(num), 0);
        tick(12);
        key_raw = 1'b0;
        tick(5);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
